iir_coef_ctrl: RTL and testbench
================================

IIR_COEF_CTRL -- requirements
Module: iir_coef_ctrl

Interface
REQ-001 Parameters SHALL be:
- NSOS, default 3: second-order sections.
- NCW, default 18: coefficient word width (4 integer, 14 fraction bits).
- FLUSH_CYC, default 16: state-clear pulse length in cycles.
- COEF_RST, default every section b0=a0=18'h04000, others 0: active bank reset value.
REQ-002 Ports SHALL be, clock and reset first (name, direction, width, meaning):
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  coefficient word valid.
- cfg_ready  out  1  coefficient word accepted.
- cfg_data  in  NCW  coefficient word.
- cfg_last  in  1  final word of the set.
- dv_in  in  1  upstream sample valid.
- d_in  in  18  upstream sample.
- flt_dv_in  out  1  sample valid to filter.
- flt_d_in  out  18  sample to filter.
- flt_dv_out  in  1  filter output valid, used only for in-flight count.
- flt_clear  out  1  filter state clear.
- coef_act  out  NSOS*6*NCW  active bank; word k of section s at bits [(s*6+k)*NCW +: NCW].
- busy  out  1  reload in progress.
- cfg_err  out  1  sticky length error.
- drop_cnt  out  16  samples dropped during reload.

Function
REQ-003 States SHALL be IDLE, DRAIN, SWAP and FLUSH.
REQ-004 cfg_ready SHALL be 1 in IDLE only; a word transfers when cfg_valid and cfg_ready are both 1.
REQ-005 Each transferred word SHALL be written to shadow[widx], and widx SHALL increment; shadow writes SHALL NOT disturb coef_act.
REQ-006 cfg_last with widx==NSOS*6-1 SHALL store the word, clear widx and go to DRAIN the next cycle.
REQ-007 cfg_last at any other widx SHALL store nothing, set cfg_err, clear widx and stay in IDLE.
REQ-008 A word with widx==NSOS*6-1 and cfg_last=0 SHALL store the word and set cfg_err; widx SHALL NOT wrap past NSOS*6-1.
REQ-009 In IDLE, flt_dv_in and flt_d_in SHALL be dv_in and d_in registered with 1-cycle latency.
REQ-010 In DRAIN, SWAP and FLUSH, flt_dv_in SHALL be 0, and each dv_in=1 SHALL increment drop_cnt, saturating at 16'hFFFF.
REQ-011 A 6-bit in-flight counter SHALL increment on flt_dv_in=1, decrement on flt_dv_out=1, hold when both occur, and never go below 0.
REQ-012 DRAIN SHALL go to SWAP in the first cycle the in-flight count is 0.
REQ-013 SWAP SHALL last one cycle, copy the whole shadow bank to coef_act and then go to FLUSH.
REQ-014 FLUSH SHALL hold flt_clear=1 for exactly FLUSH_CYC cycles, then return to IDLE; flt_clear SHALL be 0 in all other states.
REQ-015 busy SHALL be 1 in DRAIN, SWAP and FLUSH.
REQ-016 A sample with dv_in=1 in the cycle that IDLE exits SHALL pass; dropping SHALL start the first cycle in DRAIN.

Reset
REQ-017 rst=1 SHALL asynchronously force the following:
- state IDLE, widx 0, in-flight count 0, shadow 0;
- coef_act=COEF_RST;
- flt_dv_in=0, flt_d_in=0, flt_clear=0, busy=0, cfg_err=0, drop_cnt=0.
REQ-018 Reset during DRAIN, SWAP or FLUSH SHALL abort the reload; coef_act SHALL return to COEF_RST, not the shadow bank.
REQ-019 cfg_err and drop_cnt SHALL clear only on rst.

Configuration
REQ-020 With macro IIR_COEF_CTRL_DRAIN_TIMEOUT_EN defined, DRAIN SHALL be limited as follows:
- an 8-bit timer SHALL count DRAIN cycles;
- at 255 cycles the block SHALL force SWAP even if in-flight is nonzero;
- it SHALL then zero the in-flight count and set a sticky output drain_to (1 bit, reset 0).
REQ-021 Without IIR_COEF_CTRL_DRAIN_TIMEOUT_EN, DRAIN SHALL wait indefinitely, and port drain_to SHALL NOT exist.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Idle passthrough: dv_in=1, d_in=18'h1ABCD at cycle n -> flt_dv_in=1, flt_d_in=18'h1ABCD at n+1; coef_act=COEF_RST.
- Full reload: 18 words 0x00001..0x00012 with cfg_last on the 18th, no samples in flight -> DRAIN 1 cycle, SWAP, flt_clear=1 for 16 cycles, busy drops; coef_act word 17 = 0x00012.
- Drain wait: 3 samples in flight, reload, then 3 flt_dv_out pulses 10 cycles apart -> SWAP only after the third; 5 dv_in pulses during busy -> drop_cnt=5.
- Short set: cfg_last on the 4th word -> cfg_err=1, coef_act unchanged, next 18-word load succeeds.
- Reset mid-FLUSH: assert rst at FLUSH cycle 5 -> flt_clear=0 immediately, coef_act=COEF_RST, state IDLE.
- With IIR_COEF_CTRL_DRAIN_TIMEOUT_EN: flt_dv_out held 0 with 2 in flight -> SWAP after 255 DRAIN cycles, drain_to=1.

Source files
------------

// File: rtl/iir_coef_ctrl.sv
// Coefficient reload controller for a biquad cascade: shadow-bank load, drain of
// in-flight samples, one-cycle bank swap and filter state flush.
// Define IIR_COEF_CTRL_DRAIN_TIMEOUT_EN to bound DRAIN to 255 cycles (adds drain_to).
module iir_coef_ctrl #(
  parameter int NSOS      = 3,
  parameter int NCW       = 18,
  parameter int FLUSH_CYC = 16,
  // Unity b0 and a0 (1.0 in Q4.14) in every section, all other taps zero.
  parameter logic [NSOS*6*NCW-1:0] COEF_RST =
    {NSOS{{(2*NCW){1'b0}}, NCW'(18'h04000), {(2*NCW){1'b0}}, NCW'(18'h04000)}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [NCW-1:0]         cfg_data,
  input  logic                   cfg_last,
  input  logic                   dv_in,
  input  logic [17:0]            d_in,
  output logic                   flt_dv_in,
  output logic [17:0]            flt_d_in,
  input  logic                   flt_dv_out,
  output logic                   flt_clear,
  output logic [NSOS*6*NCW-1:0]  coef_act,
  output logic                   busy,
  output logic                   cfg_err,
  output logic [15:0]            drop_cnt
`ifdef IIR_COEF_CTRL_DRAIN_TIMEOUT_EN
  ,
  output logic                   drain_to
`endif
);

  localparam int NW = NSOS * 6;
  localparam int WW = (NW > 1) ? $clog2(NW) : 1;
  localparam int FW = $clog2(FLUSH_CYC + 1);
  localparam logic [WW-1:0] LAST_IDX   = WW'(NW - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, SWAP, FLUSH} state_t;

  state_t         state;
  logic [NCW-1:0] shadow [NW];
  logic [WW-1:0]  widx;
  logic [5:0]     inflight;
  logic [FW-1:0]  fcnt;
  logic           xfer;
`ifdef IIR_COEF_CTRL_DRAIN_TIMEOUT_EN
  logic [7:0]     dcnt;
`endif

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign xfer      = cfg_valid && cfg_ready;

  // NOTE: the shadow bank is reset like ordinary state so a swap can never
  // expose words left over from before the last reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) shadow[i] <= '0;
    end else if (xfer && (!cfg_last || widx == LAST_IDX)) begin
      shadow[widx] <= cfg_data;
    end
  end

  // NOTE: all assignments here are non-blocking; where two touch the same
  // register in one cycle (timeout zeroing inflight) the later one wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      widx      <= '0;
      inflight  <= '0;
      fcnt      <= '0;
      coef_act  <= COEF_RST;
      flt_dv_in <= 1'b0;
      flt_d_in  <= '0;
      flt_clear <= 1'b0;
      cfg_err   <= 1'b0;
      drop_cnt  <= '0;
`ifdef IIR_COEF_CTRL_DRAIN_TIMEOUT_EN
      dcnt      <= '0;
      drain_to  <= 1'b0;
`endif
    end else begin
      if (flt_dv_in && !flt_dv_out && inflight != 6'h3F) begin
        inflight <= inflight + 6'd1;
      end else if (!flt_dv_in && flt_dv_out && inflight != 6'd0) begin
        inflight <= inflight - 6'd1;
      end

      // Samples pass only while IDLE; anything arriving during a reload is counted.
      flt_dv_in <= (state == IDLE) && dv_in;
      if (state == IDLE) begin
        flt_d_in <= d_in;
      end else if (dv_in && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (xfer) begin
            if (cfg_last) begin
              widx <= '0;
              if (widx == LAST_IDX) state <= DRAIN;
              else                  cfg_err <= 1'b1;
            end else if (widx == LAST_IDX) begin
              cfg_err <= 1'b1;
            end else begin
              widx <= widx + WW'(1);
            end
          end
        end
        DRAIN: begin
          if (inflight == 6'd0) begin
            state <= SWAP;
          end
`ifdef IIR_COEF_CTRL_DRAIN_TIMEOUT_EN
          else if (dcnt == 8'd254) begin
            state    <= SWAP;
            inflight <= '0;
            drain_to <= 1'b1;
          end
          dcnt <= dcnt + 8'd1;
`endif
        end
        SWAP: begin
          for (int i = 0; i < NW; i++) coef_act[i*NCW +: NCW] <= shadow[i];
          fcnt      <= '0;
          flt_clear <= 1'b1;
          state     <= FLUSH;
        end
        FLUSH: begin
          if (fcnt == FLUSH_LAST) begin
            flt_clear <= 1'b0;
            state     <= IDLE;
          end else begin
            fcnt <= fcnt + FW'(1);
          end
        end
        default: state <= IDLE;
      endcase

`ifdef IIR_COEF_CTRL_DRAIN_TIMEOUT_EN
      if (state != DRAIN) dcnt <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_iir_coef_ctrl.sv
// Self-checking bench for iir_coef_ctrl: scenario tasks against a word-level
// model of the active bank, drop counter and drain/flush timing.
module tb_iir_coef_ctrl;

  localparam int NSOS = 3;
  localparam int NCW = 18;
  localparam int NW = NSOS * 6;
  localparam int FLUSH_CYC = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cfg_valid = 1'b0, cfg_last = 1'b0, dv_in = 1'b0, flt_dv_out = 1'b0;
  logic [NCW-1:0] cfg_data = '0;
  logic [17:0] d_in = '0;
  logic cfg_ready, flt_dv_in, flt_clear, busy, cfg_err;
  logic [17:0] flt_d_in;
  logic [NW*NCW-1:0] coef_act;
  logic [15:0] drop_cnt;
`ifdef IIR_COEF_CTRL_DRAIN_TIMEOUT_EN
  logic drain_to;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [NCW-1:0] bank [NW];
  logic [NCW-1:0] set_words [NW+1];

  always #5 clk = ~clk;

  iir_coef_ctrl dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .dv_in(dv_in), .d_in(d_in), .flt_dv_in(flt_dv_in), .flt_d_in(flt_d_in),
    .flt_dv_out(flt_dv_out), .flt_clear(flt_clear), .coef_act(coef_act),
    .busy(busy), .cfg_err(cfg_err), .drop_cnt(drop_cnt)
`ifdef IIR_COEF_CTRL_DRAIN_TIMEOUT_EN
    , .drain_to(drain_to)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // Reset bank: b0 (word 0) and a0 (word 3) of each section are 1.0 in Q4.14.
  task automatic rst_bank();
    for (int s = 0; s < NSOS; s++)
      for (int k = 0; k < 6; k++)
        bank[s*6+k] = (k == 0 || k == 3) ? 18'h04000 : 18'h00000;
  endtask

  function automatic logic [NW*NCW-1:0] bank_flat();
    logic [NW*NCW-1:0] r;
    for (int i = 0; i < NW; i++) r[i*NCW +: NCW] = bank[i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_last = 1'b0; cfg_data = '0;
    dv_in = 1'b0; d_in = '0; flt_dv_out = 1'b0;
    step();
    rst = 1'b0;
    rst_bank();
  endtask

  task automatic rand_set();
    for (int i = 0; i <= NW; i++) set_words[i] = 18'($urandom);
  endtask

  task automatic send_set(input int n, input bit with_last, input bit pass_last,
                          input logic [17:0] pd);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = set_words[i];
      cfg_last  = with_last && (i == n - 1);
      if (pass_last && i == n - 1) begin dv_in = 1'b1; d_in = pd; end
      step();
    end
    cfg_valid = 1'b0; cfg_last = 1'b0; dv_in = 1'b0;
  endtask

  task automatic wait_flush_start(input int bound, output int cyc);
    cyc = 0;
    while (flt_clear !== 1'b1 && cyc < bound) begin step(); cyc++; end
  endtask

  task automatic count_flush(output int n);
    n = 0;
    while (flt_clear === 1'b1 && n < FLUSH_CYC + 8) begin step(); n++; end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    rst_bank();
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cfg_ready: got %0b want 1", cfg_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (flt_dv_in !== 1'b0) begin n_bad++; $display("FAIL reset_flt_dv_in: got %0b want 0", flt_dv_in); end
    n_cmp++; if (flt_d_in !== 18'h0) begin n_bad++; $display("FAIL reset_flt_d_in: got %0h want 0", flt_d_in); end
    n_cmp++; if (flt_clear !== 1'b0) begin n_bad++; $display("FAIL reset_flt_clear: got %0b want 0", flt_clear); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_cfg_err: got %0b want 0", cfg_err); end
    n_cmp++; if (drop_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_drop_cnt: got %0h want 0", drop_cnt); end
    n_cmp++; if (coef_act !== bank_flat()) begin n_bad++; $display("FAIL reset_coef_act: got %0h want %0h", coef_act, bank_flat()); end
`ifdef IIR_COEF_CTRL_DRAIN_TIMEOUT_EN
    n_cmp++; if (drain_to !== 1'b0) begin n_bad++; $display("FAIL reset_drain_to: got %0b want 0", drain_to); end
`endif
    do_reset();
  endtask

  task automatic test_passthrough();
    logic v;
    logic [17:0] d;
    do_reset();
    for (int i = 0; i < 31; i++) begin
      v = (i == 0) ? 1'b1 : 1'($urandom);
      d = (i == 0) ? 18'h1ABCD : 18'($urandom);
      dv_in = v; d_in = d;
      step();
      n_cmp++; if (flt_dv_in !== v) begin n_bad++; $display("FAIL pass_dv[%0d]: got %0b want %0b", i, flt_dv_in, v); end
      if (v) begin
        n_cmp++; if (flt_d_in !== d) begin n_bad++; $display("FAIL pass_data[%0d]: got %0h want %0h", i, flt_d_in, d); end
      end
    end
    dv_in = 1'b0;
    n_cmp++; if (coef_act !== bank_flat()) begin n_bad++; $display("FAIL pass_coef_act: got %0h want %0h", coef_act, bank_flat()); end
  endtask

  task automatic test_full_reload();
    int cyc, n;
    do_reset();
    for (int i = 0; i < NW; i++) set_words[i] = 18'(i + 1);
    send_set(NW, 1'b1, 1'b0, '0);
    n_cmp++; if (busy !== 1'b1 || cfg_ready !== 1'b0) begin n_bad++; $display("FAIL full_busy: got busy=%0b ready=%0b want 1/0", busy, cfg_ready); end
    n_cmp++; if (coef_act !== bank_flat()) begin n_bad++; $display("FAIL full_act_before_swap: got %0h want %0h", coef_act, bank_flat()); end
    wait_flush_start(10, cyc);
    n_cmp++; if (cyc != 2) begin n_bad++; $display("FAIL full_drain_swap_cycles: got %0d want 2", cyc); end
    for (int i = 0; i < NW; i++) bank[i] = set_words[i];
    n_cmp++; if (coef_act !== bank_flat()) begin n_bad++; $display("FAIL full_coef_act: got %0h want %0h", coef_act, bank_flat()); end
    count_flush(n);
    n_cmp++; if (n != FLUSH_CYC) begin n_bad++; $display("FAIL full_flush_len: got %0d want %0d", n, FLUSH_CYC); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL full_busy_end: got %0b want 0", busy); end
    n_cmp++; if (coef_act[17*NCW +: NCW] !== 18'h00012) begin n_bad++; $display("FAIL full_word17: got %0h want 12", coef_act[17*NCW +: NCW]); end
  endtask

  task automatic test_drain_wait();
    int drop_at [5];
    int model_if, zero_c, clr_start, clr_len, leaks;
    logic [17:0] d;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      d = 18'($urandom);
      dv_in = 1'b1; d_in = d;
      step();
      n_cmp++; if (flt_d_in !== d || flt_dv_in !== 1'b1) begin n_bad++; $display("FAIL drain_pass[%0d]: got %0b/%0h want 1/%0h", i, flt_dv_in, flt_d_in, d); end
    end
    dv_in = 1'b0;
    step();
    rand_set();
    send_set(NW, 1'b1, 1'b0, '0);
    for (int j = 0; j < 5; j++) drop_at[j] = 1 + 8*j + int'($urandom_range(0, 7));
    model_if = 3; zero_c = 0; clr_start = 0; clr_len = 0; leaks = 0;
    for (int c = 1; c <= 56; c++) begin
      if (model_if == 0 && zero_c == 0) zero_c = c;
      flt_dv_out = (c == 10 || c == 20 || c == 30);
      if (flt_dv_out) model_if--;
      dv_in = 1'b0;
      for (int j = 0; j < 5; j++) if (drop_at[j] == c) dv_in = 1'b1;
      d_in = 18'($urandom);
      step();
      if (flt_clear === 1'b1) begin
        if (clr_start == 0) clr_start = c;
        clr_len++;
      end
      if (flt_dv_in !== 1'b0) leaks++;
    end
    flt_dv_out = 1'b0; dv_in = 1'b0;
    n_cmp++; if (clr_start != zero_c + 1) begin n_bad++; $display("FAIL drain_swap_time: got %0d want %0d", clr_start, zero_c + 1); end
    n_cmp++; if (clr_len != FLUSH_CYC) begin n_bad++; $display("FAIL drain_flush_len: got %0d want %0d", clr_len, FLUSH_CYC); end
    n_cmp++; if (leaks != 0) begin n_bad++; $display("FAIL drain_no_pass: got %0d samples want 0", leaks); end
    n_cmp++; if (drop_cnt !== 16'd5) begin n_bad++; $display("FAIL drain_drop_cnt: got %0d want 5", drop_cnt); end
    for (int i = 0; i < NW; i++) bank[i] = set_words[i];
    n_cmp++; if (coef_act !== bank_flat()) begin n_bad++; $display("FAIL drain_coef_act: got %0h want %0h", coef_act, bank_flat()); end
  endtask

  task automatic test_exit_boundary();
    logic [17:0] pd;
    do_reset();
    rand_set();
    pd = 18'($urandom);
    send_set(NW, 1'b1, 1'b1, pd);
    n_cmp++; if (flt_dv_in !== 1'b1 || flt_d_in !== pd) begin n_bad++; $display("FAIL exit_pass: got %0b/%0h want 1/%0h", flt_dv_in, flt_d_in, pd); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL exit_no_drop: got %0d want 0", drop_cnt); end
    dv_in = 1'b1; d_in = 18'($urandom);
    step();
    dv_in = 1'b0;
    n_cmp++; if (drop_cnt !== 16'd1 || flt_dv_in !== 1'b0) begin n_bad++; $display("FAIL exit_first_drop: got cnt=%0d dv=%0b want 1/0", drop_cnt, flt_dv_in); end
  endtask

  task automatic test_short_set();
    int cyc, n;
    do_reset();
    rand_set();
    send_set(4, 1'b1, 1'b0, '0);
    n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL short_cfg_err: got %0b want 1", cfg_err); end
    repeat (3) step();
    n_cmp++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin n_bad++; $display("FAIL short_stay_idle: got busy=%0b ready=%0b want 0/1", busy, cfg_ready); end
    n_cmp++; if (coef_act !== bank_flat()) begin n_bad++; $display("FAIL short_coef_act: got %0h want %0h", coef_act, bank_flat()); end
    rand_set();
    send_set(NW, 1'b1, 1'b0, '0);
    wait_flush_start(10, cyc);
    n_cmp++; if (cyc != 2) begin n_bad++; $display("FAIL short_reload_start: got %0d want 2", cyc); end
    count_flush(n);
    for (int i = 0; i < NW; i++) bank[i] = set_words[i];
    n_cmp++; if (coef_act !== bank_flat()) begin n_bad++; $display("FAIL short_reload_act: got %0h want %0h", coef_act, bank_flat()); end
    n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL short_err_sticky: got %0b want 1", cfg_err); end
  endtask

  task automatic test_overrun();
    int cyc, n;
    do_reset();
    rand_set();
    send_set(NW, 1'b0, 1'b0, '0);
    n_cmp++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL over_err: got err=%0b busy=%0b want 1/0", cfg_err, busy); end
    cfg_valid = 1'b1; cfg_data = set_words[NW]; cfg_last = 1'b1;
    step();
    cfg_valid = 1'b0; cfg_last = 1'b0;
    wait_flush_start(10, cyc);
    count_flush(n);
    for (int i = 0; i < NW - 1; i++) bank[i] = set_words[i];
    bank[NW-1] = set_words[NW];
    n_cmp++; if (coef_act !== bank_flat()) begin n_bad++; $display("FAIL over_coef_act: got %0h want %0h", coef_act, bank_flat()); end
  endtask

  task automatic test_reset_mid_flush();
    int cyc;
    logic [17:0] d;
    do_reset();
    rand_set();
    send_set(NW, 1'b1, 1'b0, '0);
    wait_flush_start(10, cyc);
    repeat (4) step();
    n_cmp++; if (flt_clear !== 1'b1) begin n_bad++; $display("FAIL midflush_in_flush: got %0b want 1", flt_clear); end
    #2 rst = 1'b1;
    #1;
    rst_bank();
    n_cmp++; if (flt_clear !== 1'b0) begin n_bad++; $display("FAIL midflush_clear: got %0b want 0", flt_clear); end
    n_cmp++; if (coef_act !== bank_flat()) begin n_bad++; $display("FAIL midflush_coef_act: got %0h want %0h", coef_act, bank_flat()); end
    n_cmp++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin n_bad++; $display("FAIL midflush_idle: got busy=%0b ready=%0b want 0/1", busy, cfg_ready); end
    #1 rst = 1'b0;
    d = 18'($urandom);
    dv_in = 1'b1; d_in = d;
    step();
    dv_in = 1'b0;
    n_cmp++; if (flt_dv_in !== 1'b1 || flt_d_in !== d) begin n_bad++; $display("FAIL midflush_pass: got %0b/%0h want 1/%0h", flt_dv_in, flt_d_in, d); end
  endtask

`ifdef IIR_COEF_CTRL_DRAIN_TIMEOUT_EN
  task automatic test_drain_timeout();
    int cyc, n;
    do_reset();
    dv_in = 1'b1;
    repeat (2) step();
    dv_in = 1'b0;
    step();
    rand_set();
    send_set(NW, 1'b1, 1'b0, '0);
    n_cmp++; if (drain_to !== 1'b0) begin n_bad++; $display("FAIL to_before: got %0b want 0", drain_to); end
    wait_flush_start(400, cyc);
    n_cmp++; if (cyc != 256) begin n_bad++; $display("FAIL to_swap_time: got %0d want 256", cyc); end
    n_cmp++; if (drain_to !== 1'b1) begin n_bad++; $display("FAIL to_flag: got %0b want 1", drain_to); end
    count_flush(n);
    for (int i = 0; i < NW; i++) bank[i] = set_words[i];
    n_cmp++; if (coef_act !== bank_flat()) begin n_bad++; $display("FAIL to_coef_act: got %0h want %0h", coef_act, bank_flat()); end
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_full_reload();
    test_drain_wait();
    test_exit_boundary();
    test_short_set();
    test_overrun();
    test_reset_mid_flush();
`ifdef IIR_COEF_CTRL_DRAIN_TIMEOUT_EN
    test_drain_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
